// File: rtl/ic_event_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ic_pkg
// Description : Shared widths, event entry type and helpers for ic_event_fifo.
//               IC_DELTA_EN adds a delta field to the event entry.
// Revision    : 1.0 - initial release
// ============================================================================
package ic_pkg;

    localparam int TS_W   = 16;
    localparam int CNT_W  = 16;
    localparam int DROP_W = 8;

    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [CNT_W-1:0] cnt;
`ifdef IC_DELTA_EN
        logic [TS_W-1:0]  delta;
`endif
    } ic_event_t;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

endpackage : ic_pkg
`default_nettype wire

// File: rtl/ic_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ic_sync_fifo
// Description : Generic first-word-fall-through register FIFO with flush,
//               fill level (current and next) and full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ic_sync_fifo #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o,
    output logic [LVL_W-1:0] level_nxt_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             full;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign pop_ok  = pop_i & ~empty & ~clr_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push_i & ~clr_i & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        head_d   = head_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                level_d = level_q + LVL_W'(1);
            end else if (!push_ok && pop_ok) begin
                level_d = level_q - LVL_W'(1);
            end
            // The new head may be the word being written this cycle (bypass).
            if (level_d != '0) begin
                head_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? wdata_i : mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    assign rdata_o     = head_q;
    assign full_o      = full;
    assign empty_o     = empty;
    assign level_o     = level_q;
    assign level_nxt_o = level_d;

endmodule : ic_sync_fifo
`default_nettype wire

// File: rtl/ic_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ic_event_fifo
// Description : Timestamps input-capture events and buffers them in a FWFT
//               FIFO with drop counting and a level/overflow interrupt.
//               Define IC_DELTA_EN to add the o_ev_delta output.
// Revision    : 1.0 - initial release
// ============================================================================
module ic_event_fifo
    import ic_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter int  IRQ_LVL = 4,
    localparam int LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic              i_sysclk,
    input  logic              i_sysrst_n,
    input  logic              i_clr,
    input  logic              i_ts_en,
    input  logic              i_ic_flg,
    input  logic [CNT_W-1:0]  i_cnt_data,
    output logic              o_ev_valid,
    input  logic              i_ev_ready,
    output logic [TS_W-1:0]   o_ev_ts,
    output logic [CNT_W-1:0]  o_ev_cnt,
`ifdef IC_DELTA_EN
    output logic [TS_W-1:0]   o_ev_delta,
`endif
    output logic [LVL_W-1:0]  o_level,
    output logic              o_ovf,
    output logic [DROP_W-1:0] o_drop_cnt,
    input  logic              i_ovf_clr,
    output logic              o_irq
);

    logic [TS_W-1:0]   ts_q, ts_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              irq_q, irq_d;

    ic_event_t         wr_ev;
    ic_event_t         rd_ev;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  level;
    logic [LVL_W-1:0]  level_nxt;
    logic              pop_req;
    logic              drop;

    assign pop_req = ~fifo_empty & i_ev_ready;
    assign drop    = i_ic_flg & fifo_full & ~pop_req & ~i_clr;

    always_comb begin
        ts_d = ts_q;
        if (i_clr) begin
            ts_d = '0;
        end else if (i_ts_en) begin
            ts_d = ts_q + TS_W'(1);
        end
    end

`ifdef IC_DELTA_EN
    logic [TS_W-1:0] prev_ts_q, prev_ts_d;
    logic            have_prev_q, have_prev_d;
    logic            push_ok;

    // Only accepted events advance the delta reference; drops leave it alone.
    assign push_ok = i_ic_flg & ~i_clr & (~fifo_full | pop_req);

    always_comb begin
        prev_ts_d   = prev_ts_q;
        have_prev_d = have_prev_q;
        if (i_clr) begin
            prev_ts_d   = '0;
            have_prev_d = 1'b0;
        end else if (push_ok) begin
            prev_ts_d   = ts_q;
            have_prev_d = 1'b1;
        end
    end

    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            prev_ts_q   <= '0;
            have_prev_q <= 1'b0;
        end else begin
            prev_ts_q   <= prev_ts_d;
            have_prev_q <= have_prev_d;
        end
    end
`endif

    always_comb begin
        wr_ev     = '0;
        wr_ev.ts  = ts_q;
        wr_ev.cnt = i_cnt_data;
`ifdef IC_DELTA_EN
        wr_ev.delta = have_prev_q ? (ts_q - prev_ts_q) : '0;
`endif
    end

    ic_sync_fifo #(
        .WIDTH ($bits(ic_event_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (i_sysclk),
        .rst_ni      (i_sysrst_n),
        .clr_i       (i_clr),
        .push_i      (i_ic_flg),
        .wdata_i     (wr_ev),
        .pop_i       (i_ev_ready),
        .rdata_o     (rd_ev),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (level),
        .level_nxt_o (level_nxt)
    );

    // A drop in the same cycle as i_ovf_clr restarts the count at one.
    always_comb begin
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (i_clr) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            ovf_d      = 1'b1;
            drop_cnt_d = i_ovf_clr ? DROP_W'(1) : sat_inc(drop_cnt_q);
        end else if (i_ovf_clr) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end
        irq_d = ~i_clr & ((level_nxt >= LVL_W'(IRQ_LVL)) | ovf_d);
    end

    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            ts_q       <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
            irq_q      <= irq_d;
        end
    end

    assign o_ev_valid = ~fifo_empty;
    assign o_ev_ts    = rd_ev.ts;
    assign o_ev_cnt   = rd_ev.cnt;
`ifdef IC_DELTA_EN
    assign o_ev_delta = rd_ev.delta;
`endif
    assign o_level    = level;
    assign o_ovf      = ovf_q;
    assign o_drop_cnt = drop_cnt_q;
    assign o_irq      = irq_q;

endmodule : ic_event_fifo
`default_nettype wire

// File: tb/tb_ic_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ic_event_fifo
// Description : Self-checking bench for ic_event_fifo against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ic_event_fifo;

    localparam int DEPTH   = 8;
    localparam int IRQ_LVL = 4;
    localparam int LVL_W   = 4;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        clr      = 1'b0;
    logic        ts_en    = 1'b0;
    logic        flg      = 1'b0;
    logic [15:0] cnt_data = 16'h0;
    logic        rdy      = 1'b0;
    logic        ovf_clr  = 1'b0;

    logic             ev_valid;
    logic [15:0]      ev_ts;
    logic [15:0]      ev_cnt;
    logic [15:0]      ev_delta;
    logic [LVL_W-1:0] level;
    logic             ovf;
    logic [7:0]       drop_cnt;
    logic             irq;

    int errors = 0;
    int checks = 0;

    ic_event_fifo #(
        .DEPTH   (DEPTH),
        .IRQ_LVL (IRQ_LVL)
    ) dut (
        .i_sysclk   (clk),
        .i_sysrst_n (rst_n),
        .i_clr      (clr),
        .i_ts_en    (ts_en),
        .i_ic_flg   (flg),
        .i_cnt_data (cnt_data),
        .o_ev_valid (ev_valid),
        .i_ev_ready (rdy),
        .o_ev_ts    (ev_ts),
        .o_ev_cnt   (ev_cnt),
`ifdef IC_DELTA_EN
        .o_ev_delta (ev_delta),
`endif
        .o_level    (level),
        .o_ovf      (ovf),
        .o_drop_cnt (drop_cnt),
        .i_ovf_clr  (ovf_clr),
        .o_irq      (irq)
    );

`ifndef IC_DELTA_EN
    assign ev_delta = 16'h0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of events plus plain counters.
    typedef struct packed {
        logic [15:0] ts;
        logic [15:0] cnt;
        logic [15:0] delta;
    } mev_t;

    mev_t        mq[$];
    mev_t        m_new;
    logic [15:0] m_ts    = 16'h0;
    logic [15:0] m_prev  = 16'h0;
    bit          m_first = 1'b1;
    bit          m_ovf   = 1'b0;
    int          m_drop  = 0;
    bit          m_irq   = 1'b0;
    bit          m_pop;
    bit          m_acc;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_ts = 0; m_prev = 0; m_first = 1; m_ovf = 0; m_drop = 0; m_irq = 0;
        end else if (clr) begin
            mq.delete();
            m_ts = 0; m_prev = 0; m_first = 1; m_ovf = 0; m_drop = 0; m_irq = 0;
        end else begin
            m_pop = (mq.size() > 0) && rdy;
            m_acc = flg && ((mq.size() < DEPTH) || m_pop);
            if (m_pop) void'(mq.pop_front());
            if (m_acc) begin
                m_new.ts    = m_ts;
                m_new.cnt   = cnt_data;
                m_new.delta = m_first ? 16'h0 : 16'(m_ts - m_prev);
                mq.push_back(m_new);
                m_prev  = m_ts;
                m_first = 0;
            end
            if (flg && !m_acc) begin
                m_ovf  = 1;
                m_drop = ovf_clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
            end else if (ovf_clr) begin
                m_ovf  = 0;
                m_drop = 0;
            end
            m_irq = (mq.size() >= IRQ_LVL) || m_ovf;
            if (ts_en) m_ts = m_ts + 16'h1;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("cmp_valid", 32'(ev_valid), 32'(mq.size() != 0));
        chk("cmp_level", 32'(level), 32'(mq.size()));
        chk("cmp_ovf", 32'(ovf), 32'(m_ovf));
        chk("cmp_drop", 32'(drop_cnt), 32'(m_drop));
        chk("cmp_irq", 32'(irq), 32'(m_irq));
        if (mq.size() != 0) begin
            chk("cmp_ts", 32'(ev_ts), 32'(mq[0].ts));
            chk("cmp_cnt", 32'(ev_cnt), 32'(mq[0].cnt));
`ifdef IC_DELTA_EN
            chk("cmp_delta", 32'(ev_delta), 32'(mq[0].delta));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(ev_valid), 0);
        chk({tag, "_level"}, 32'(level), 0);
        chk({tag, "_ovf"}, 32'(ovf), 0);
        chk({tag, "_drop"}, 32'(drop_cnt), 0);
        chk({tag, "_irq"}, 32'(irq), 0);
        chk({tag, "_ts"}, 32'(ev_ts), 0);
        chk({tag, "_cnt"}, 32'(ev_cnt), 0);
    endtask

    initial begin
        tick();
        tick();
        chk_zero("reset");
        rst_n = 1'b1;

        // Single event at timestamp 5
        clr = 1; ts_en = 1; tick(); clr = 0;
        repeat (5) tick();
        flg = 1; cnt_data = 16'h0001; tick(); flg = 0;
        chk("single_valid", 32'(ev_valid), 1);
        chk("single_ts", 32'(ev_ts), 32'h5);
        chk("single_cnt", 32'(ev_cnt), 32'h1);
        chk("single_level", 32'(level), 1);
        rdy = 1; tick(); rdy = 0;
        chk("single_pop_valid", 32'(ev_valid), 0);
        chk("single_pop_level", 32'(level), 0);

        // Fill past full, then push+pop while full
        clr = 1; tick(); clr = 0;
        for (int i = 1; i <= 10; i++) begin
            flg = 1; cnt_data = 16'(i); tick();
        end
        flg = 0;
        chk("fill_level", 32'(level), 8);
        chk("fill_ovf", 32'(ovf), 1);
        chk("fill_drop", 32'(drop_cnt), 2);
        chk("fill_irq", 32'(irq), 1);
        chk("fill_head", 32'(ev_cnt), 1);
        flg = 1; cnt_data = 16'h0099; rdy = 1; tick(); flg = 0; rdy = 0;
        chk("fullpp_level", 32'(level), 8);
        chk("fullpp_drop", 32'(drop_cnt), 2);
        for (int i = 0; i < 8; i++) begin
            chk("drain_cnt", 32'(ev_cnt), (i < 7) ? i + 2 : 32'h99);
            rdy = 1; tick();
        end
        rdy = 0;
        chk("drain_level", 32'(level), 0);
        chk("drain_irq_ovf", 32'(irq), 1);
        ovf_clr = 1; tick(); ovf_clr = 0;
        chk("ovfclr_ovf", 32'(ovf), 0);
        chk("ovfclr_drop", 32'(drop_cnt), 0);
        chk("ovfclr_irq", 32'(irq), 0);

        // Drop counter saturation, then drop racing ovf_clr
        flg = 1; repeat (8 + 260) tick();
        chk("sat_drop", 32'(drop_cnt), 255);
        ovf_clr = 1; tick(); ovf_clr = 0; flg = 0;
        chk("race_ovf", 32'(ovf), 1);
        chk("race_drop", 32'(drop_cnt), 1);

        // Clear beats a simultaneous push and pop
        clr = 1; tick(); clr = 0;
        for (int i = 0; i < 3; i++) begin
            flg = 1; cnt_data = 16'(16'h40 + i); tick();
        end
        flg = 0;
        chk("clr_pre_level", 32'(level), 3);
        clr = 1; flg = 1; rdy = 1; tick(); clr = 0; flg = 0; rdy = 0;
        chk("clr_level", 32'(level), 0);
        chk("clr_valid", 32'(ev_valid), 0);
        chk("clr_irq", 32'(irq), 0);
        ts_en = 0; flg = 1; cnt_data = 16'h0055; tick(); flg = 0;
        chk("clr_ts", 32'(ev_ts), 0);
        chk("clr_delta", 32'(ev_delta), 0);

        // Asynchronous reset between edges at level 5
        ts_en = 1;
        for (int i = 0; i < 4; i++) begin
            flg = 1; cnt_data = 16'(16'h60 + i); tick();
        end
        flg = 0;
        chk("arst_pre_level", 32'(level), 5);
        chk("arst_pre_irq", 32'(irq), 1);
        #2 rst_n = 0;
        #1 chk_zero("arst");
        tick();
        rst_n = 1;

        // Randomized traffic with shifting ready/flag bias
        for (int blk = 0; blk < 15; blk++) begin
            automatic int rdy_pct = $urandom_range(10, 90);
            automatic int flg_pct = $urandom_range(20, 80);
            for (int c = 0; c < 100; c++) begin
                flg      = ($urandom_range(99) < flg_pct);
                rdy      = ($urandom_range(99) < rdy_pct);
                cnt_data = 16'($urandom);
                ts_en    = ($urandom_range(99) < 80);
                ovf_clr  = ($urandom_range(29) == 0);
                clr      = ($urandom_range(99) == 0);
                tick();
            end
        end
        flg = 0; rdy = 0; ovf_clr = 0; clr = 0;

        // Timer wrap: captures at 0xFFFF and 0x0001
        clr = 1; ts_en = 1; tick(); clr = 0;
        repeat (65535) tick();
        flg = 1; cnt_data = 16'h00A1; tick(); flg = 0; tick();
        flg = 1; cnt_data = 16'h00A2; tick(); flg = 0;
        chk("wrap_level", 32'(level), 2);
        chk("wrap_ts0", 32'(ev_ts), 32'hFFFF);
        chk("wrap_delta0", 32'(ev_delta), 0);
        rdy = 1; tick(); rdy = 0;
        chk("wrap_ts1", 32'(ev_ts), 32'h0001);
        chk("wrap_cnt1", 32'(ev_cnt), 32'h00A2);
`ifdef IC_DELTA_EN
        chk("wrap_delta1", 32'(ev_delta), 32'h0002);
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ic_event_fifo
`default_nettype wire

// File: doc/ic_event_fifo.md
Name: ic_event_fifo

Overview:
- Sits directly downstream of the input-capture counter.
- Consumes its one-cycle capture flag and 16-bit count, and timestamps each capture with a free-running 16-bit timer.
- Buffers {timestamp, count} events in a small first-word-fall-through FIFO for the register/host side to drain over a valid/ready interface.
- Reports overflow and raises a level/overflow interrupt.

Parameters:
- DEPTH, 8, number of FIFO entries; power of 2, minimum 2.
- IRQ_LVL, 4, fill level at or above which o_irq asserts; range 1..DEPTH.

Ports:
- i_sysclk  in  1  system clock; the only clock.
- i_sysrst_n  in  1  system reset.
- i_clr  in  1  synchronous flush: clears FIFO, timer, overflow, drop count.
- i_ts_en  in  1  timestamp timer count enable.
- i_ic_flg  in  1  capture pulse from the input-capture stage.
- i_cnt_data  in  16  capture count, valid in the same cycle as i_ic_flg.
- o_ev_valid  out  1  FIFO head entry available.
- i_ev_ready  in  1  consumer accepts the head entry.
- o_ev_ts  out  16  timestamp of the head entry.
- o_ev_cnt  out  16  count of the head entry.
- o_level  out  clog2(DEPTH)+1  current fill level.
- o_ovf  out  1  sticky: an event was dropped.
- o_drop_cnt  out  8  dropped events, saturating at 255.
- i_ovf_clr  in  1  clears o_ovf and o_drop_cnt.
- o_irq  out  1  interrupt request.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, timer 0, pointers 0.
- Timer r_ts:
  - Increments by 1 each cycle while i_ts_en = 1.
  - Wraps 0xFFFF -> 0x0000.
  - Holds while i_ts_en = 0.
- Push:
  - On a cycle with i_ic_flg = 1, the entry {r_ts current value, i_cnt_data} is written.
  - i_cnt_data is taken as-is: the upstream flag and count update on the same edge.
  - The pushed entry is visible on the outputs the next cycle (o_ev_valid = 1 if it was empty).
- Pop:
  - Occurs when o_ev_valid and i_ev_ready are both 1.
  - The next entry appears the following cycle.
  - o_ev_ts and o_ev_cnt are driven from the head register (FWFT); they hold stable while valid and not ready.
  - When empty, o_ev_ts and o_ev_cnt hold their last values; the consumer must ignore them.
- o_level tracks entries:
  - +1 on push.
  - -1 on pop.
  - Unchanged on a simultaneous push and pop.
- Full:
  - A push while full with no same-cycle pop is dropped.
  - The drop sets o_ovf (sticky) and increments o_drop_cnt (saturates at 255).
  - A push and pop in the same cycle while full are both accepted; no drop.
- Empty:
  - Push and i_ev_ready in the same cycle: no pop (valid was 0); the push is accepted.
- Overflow clearing:
  - i_ovf_clr clears o_ovf and o_drop_cnt next cycle.
  - A drop in the same cycle wins: o_ovf = 1, o_drop_cnt = 1.
- i_clr:
  - Highest priority.
  - Next cycle: pointers, o_level, r_ts, o_ovf and o_drop_cnt are all 0, and o_ev_valid = 0.
  - Same-cycle push and pop are ignored.
- o_irq:
  - Registered: o_irq = (next level >= IRQ_LVL) | next o_ovf.
  - Asserts the cycle after the causing push or drop.
- Pointers: clog2(DEPTH) bits, natural wrap; full/empty derived from the level counter.
- Reset mid-operation: immediate asynchronous return to reset values; storage contents are don't-care.

Optional Feature:
- Macro: IC_DELTA_EN.
- Defined:
  - Each entry additionally stores a 16-bit delta = r_ts − previous captured r_ts (mod 2^16), exposed on port o_ev_delta [15:0].
  - The first accepted event after reset or i_clr gets delta 0.
  - Dropped events do not update the previous timestamp.
- Undefined: no delta storage, no o_ev_delta port; all other behaviour is identical.

Decomposition:
- Package ic_pkg:
  - TS_W = 16, CNT_W = 16, DROP_W = 8.
  - Entry typedef ic_event_t {ts, cnt[, delta]}.
- Sub-module ic_sync_fifo:
  - Generic width/depth FWFT register FIFO with push/pop/clr, level, full and empty.
  - ic_event_fifo wraps it with the timer, the drop/overflow logic and the irq.

Test Plan:
- Single event: reset, i_ts_en = 1, pulse i_ic_flg with i_cnt_data = 0x0001 at r_ts = 0x0005 -> next cycle o_ev_valid = 1, o_ev_ts = 0x0005, o_ev_cnt = 0x0001, o_level = 1; pulse i_ev_ready -> o_ev_valid = 0, o_level = 0.
- Fill and overflow: DEPTH = 8, 10 pulses with no ready -> o_level = 8, o_ovf = 1, o_drop_cnt = 2, o_irq = 1; drain 8 entries -> counts 1..8 in order; i_ovf_clr -> o_ovf = 0, o_drop_cnt = 0, o_irq = 0.
- Full with simultaneous push and pop: at level 8, pulse i_ic_flg with i_ev_ready = 1 -> level stays 8, no drop, new entry read out last.
- Timer wrap: i_ts_en held from r_ts = 0xFFFE, capture on 0xFFFF and again 2 cycles later -> ts 0xFFFF and 0x0001; with IC_DELTA_EN, deltas 0 and 0x0002.
- Clear priority: i_clr together with i_ic_flg and i_ev_ready at level 3 -> next cycle level 0, o_ev_valid = 0, r_ts = 0, o_irq = 0.
- Async reset mid-burst: assert i_sysrst_n = 0 between clock edges at level 5 -> all outputs 0 immediately, without waiting for a clock edge.
